// File: rtl/param_sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parameterised single-clock FIFO.
package param_sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int t, input int depth);
        return (t >= 0) && (t <= depth);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus of the FIFO; the FIFO sits on the slave side.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                      wren;
    logic [DATA_WIDTH-1:0]     i_data;
    logic                      rden;
    logic [DATA_WIDTH-1:0]     o_data;
    logic                      o_valid;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wren, i_data, rden,
        input  o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wren, i_data, rden,
        output o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with selectable standard/FWFT read, fill count, programmable
// almost flags and overflow/underflow strobes.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);
    localparam int         AW   = $clog2(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C   = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_C   = (AW + 1)'(AE_THRESH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
    end
    if (!thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH=%0d outside 0..DEPTH", AF_THRESH);
    end
    if (!thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH=%0d outside 0..DEPTH", AE_THRESH);
    end

    logic [AW:0]           wrptr, rdptr, cnt;
    logic                  full_c, empty_c;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ovf_q, unf_q;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign full_c  = (cnt == FULL_C);
    assign empty_c = (cnt == '0);
    assign wr_acc  = bus.wren && !full_c;
    assign rd_acc  = bus.rden && !empty_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wrptr <= wrptr + {{AW{1'b0}}, wr_acc};
            rdptr <= rdptr + {{AW{1'b0}}, rd_acc};
            cnt   <= cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
            ovf_q <= bus.wren && full_c;
            unf_q <= bus.rden && empty_c;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wrptr[AW-1:0]),
        .wdata (bus.i_data),
        .raddr (rdptr[AW-1:0]),
        .rdata (rd_data)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head is masked while empty so stale RAM contents never show on o_data.
        assign bus.o_valid = !empty_c;
        assign bus.o_data  = empty_c ? '0 : rd_data;
    end else begin : g_std
        logic                  vld_q;
        logic [DATA_WIDTH-1:0] dat_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= rd_acc;
                if (rd_acc) dat_q <= rd_data;
            end
        end

        assign bus.o_valid = vld_q;
        assign bus.o_data  = dat_q;
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical traffic and checks
// both against a queue model of the contents plus a scoreboard of read results.
module tb_param_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wren = 1'b0;
    logic       rden = 1'b0;
    logic [7:0] i_data = '0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_std = '0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) s_if ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) f_if ();

    assign s_if.wren = wren;  assign s_if.rden = rden;  assign s_if.i_data = i_data;
    assign f_if.wren = wren;  assign f_if.rden = rden;  assign f_if.i_data = i_data;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1))
        u_std (.clk(clk), .rst(rst), .bus(s_if.slave));
    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1))
        u_fwft (.clk(clk), .rst(rst), .bus(f_if.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string m, input logic [3:0] cnt, input logic fl,
                             input logic em, input logic af, input logic ae,
                             input logic ov, input logic un, input bit eov, input bit eun);
        int n = mq.size();
        chk({m, "_count"}, 32'(cnt), 32'(n));
        chk({m, "_full"}, 32'(fl), 32'(n == 8));
        chk({m, "_empty"}, 32'(em), 32'(n == 0));
        chk({m, "_afull"}, 32'(af), 32'(n >= 6));
        chk({m, "_aempty"}, 32'(ae), 32'(n <= 1));
        chk({m, "_overflow"}, 32'(ov), 32'(eov));
        chk({m, "_underflow"}, 32'(un), 32'(eun));
    endtask

    // One clock of traffic: the model decides acceptance from pre-edge occupancy.
    task automatic cyc(input bit w, input logic [7:0] d, input bit r);
        int  n    = mq.size();
        bit  wacc = w && (n < 8);
        bit  racc = r && (n > 0);
        bit  eov  = w && (n == 8);
        bit  eun  = r && (n == 0);
        wren = w; i_data = d; rden = r;
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0;
        chk_flags("std", s_if.count, s_if.full, s_if.empty, s_if.almost_full,
                  s_if.almost_empty, s_if.overflow, s_if.underflow, eov, eun);
        chk_flags("fwft", f_if.count, f_if.full, f_if.empty, f_if.almost_full,
                  f_if.almost_empty, f_if.overflow, f_if.underflow, eov, eun);
        chk("std_valid", 32'(s_if.o_valid), 32'(racc));
        if (racc && exp_q.size() > 0) last_std = exp_q.pop_front();
        chk("std_data", 32'(s_if.o_data), 32'(last_std));
        chk("fwft_valid", 32'(f_if.o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("fwft_data", 32'(f_if.o_data), 32'(mq[0]));
    endtask

    task automatic do_reset(input bit busy);
        rst = 1'b1; wren = busy; rden = busy; i_data = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wren = 1'b0; rden = 1'b0;
        mq.delete(); exp_q.delete(); last_std = '0;
        chk_flags("std_rst", s_if.count, s_if.full, s_if.empty, s_if.almost_full,
                  s_if.almost_empty, s_if.overflow, s_if.underflow, 1'b0, 1'b0);
        chk_flags("fwft_rst", f_if.count, f_if.full, f_if.empty, f_if.almost_full,
                  f_if.almost_empty, f_if.overflow, f_if.underflow, 1'b0, 1'b0);
        chk("std_rst_valid", 32'(s_if.o_valid), 32'(0));
        chk("std_rst_data", 32'(s_if.o_data), 32'(0));
        chk("fwft_rst_valid", 32'(f_if.o_valid), 32'(0));
        chk("fwft_rst_data", 32'(f_if.o_data), 32'(0));
    endtask

    initial begin
        do_reset(1'b0);

        // Fill to full, one dropped write, then drain in order
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Underflow on empty
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Steady simultaneous traffic at count 4; pointers wrap several times
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h20 + i), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 8'hEE, 1'b1);                       // full: only the read goes
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);                       // empty: only the write goes
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Latency: write to empty, idle, then a single read
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Step count up to 8 and back to 0 with random data
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        // Reset in the middle of traffic with a read in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        wren = 1'b1; rden = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
